// File: rtl/baud_pkg.sv
// Shared constants for the baud generator: rate codes, baud table,
// rounded divisor function and the lower divisor bound.
package baud_pkg;

   typedef enum logic [2:0] {
      BPS_9600   = 3'd0,
      BPS_19200  = 3'd1,
      BPS_38400  = 3'd2,
      BPS_57600  = 3'd3,
      BPS_115200 = 3'd4,
      BPS_4800   = 3'd5,
      BPS_2400   = 3'd6,
      BPS_CUSTOM = 3'd7
   } bps_e;

   // Smallest divisor without the oversample build; the oversample build
   // raises the bound to OVS so every bit period holds OVS ticks.
   localparam int NMIN_BASE = 2;

   function automatic int baud_of(input int code);
      case (code)
         0:       return 9600;
         1:       return 19200;
         2:       return 38400;
         3:       return 57600;
         4:       return 115200;
         5:       return 4800;
         6:       return 2400;
         default: return 9600;
      endcase
   endfunction

   function automatic int div_of(input int clk_hz, input int code);
      int baud;
      baud = baud_of(code);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/baud_ovs_nco.sv
// Oversample accumulator: adds OVS each advancing cycle and emits a tick
// whenever the sum crosses the divisor, giving exactly OVS ticks per period.
module baud_ovs_nco #(
   parameter int DIV_W = 16,
   parameter int OVS   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             ovs_tick
);

   localparam logic [DIV_W:0] STEP = (DIV_W+1)'(OVS);

   logic [DIV_W:0] acc;
   logic [DIV_W:0] sum;

   always_comb sum = acc + STEP;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         ovs_tick <= 1'b0;
      end else if (clear) begin
         acc      <= '0;
         ovs_tick <= 1'b0;
      end else if (en) begin
         if (sum >= {1'b0, div}) begin
            acc      <= sum - {1'b0, div};
            ovs_tick <= 1'b1;
         end else begin
            acc      <= sum;
            ovs_tick <= 1'b0;
         end
      end else begin
         ovs_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/baud_gen.sv
// Baud-rate generator: bit clock, bit tick and (with BAUD_OVS_EN defined)
// an oversample tick. All outputs are registered one cycle after the counter.
module baud_gen
   import baud_pkg::*;
#(
   parameter int CLK_HZ = 16_000_000,
   parameter int DIV_W  = 16,
   parameter int OVS    = 16
) (
   input  logic             clk_16m,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       bps_set,
   input  logic [DIV_W-1:0] div_custom,
   input  logic             sync,
   output logic             clk_bps,
   output logic             bps_tick,
   output logic             ovs_tick,
   output logic [DIV_W-1:0] div_active
);

`ifdef BAUD_OVS_EN
   localparam int NMIN = OVS;
`else
   localparam int NMIN = NMIN_BASE;
`endif

   localparam logic [DIV_W-1:0] DIV_TAB [0:7] = '{
      DIV_W'(div_of(CLK_HZ, 0)), DIV_W'(div_of(CLK_HZ, 1)),
      DIV_W'(div_of(CLK_HZ, 2)), DIV_W'(div_of(CLK_HZ, 3)),
      DIV_W'(div_of(CLK_HZ, 4)), DIV_W'(div_of(CLK_HZ, 5)),
      DIV_W'(div_of(CLK_HZ, 6)), '0
   };

   localparam logic [DIV_W-1:0] DIV_RST =
      (div_of(CLK_HZ, 0) < NMIN) ? DIV_W'(NMIN) : DIV_TAB[0];

   for (genvar c = 0; c < 7; c++) begin : g_chk
      if ((div_of(CLK_HZ, c) >> DIV_W) != 0) begin : g_err
         $error("baud_gen: divisor for rate code %0d exceeds DIV_W", c);
      end
   end

   if (OVS < 1 || (OVS >> DIV_W) != 0) begin : g_ovs_err
      $error("baud_gen: OVS out of range");
   end

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] raw_div;
   logic [DIV_W-1:0] sel_div;
   logic             run;
   logic             adv;
   logic             wrap;

   always_comb begin
      raw_div = DIV_TAB[bps_set];
      if (bps_set == BPS_CUSTOM) raw_div = div_custom;
      sel_div = (raw_div < DIV_W'(NMIN)) ? DIV_W'(NMIN) : raw_div;
   end

   // run is low on the first enabled cycle, which only latches the rate.
   always_comb begin
      adv  = en && run && !sync;
      wrap = adv && (cnt == div_active - 1'b1);
   end

   always_ff @(posedge clk_16m or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         run        <= 1'b0;
         div_active <= DIV_RST;
         clk_bps    <= 1'b0;
         bps_tick   <= 1'b0;
      end else if (!en) begin
         cnt      <= '0;
         run      <= 1'b0;
         clk_bps  <= 1'b0;
         bps_tick <= 1'b0;
      end else begin
         run      <= 1'b1;
         clk_bps  <= run && (cnt >= (div_active >> 1));
         bps_tick <= wrap;
         if (!adv || wrap) begin
            cnt        <= '0;
            div_active <= sel_div;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef BAUD_OVS_EN
   baud_ovs_nco #(
      .DIV_W (DIV_W),
      .OVS   (OVS)
   ) u_nco (
      .clk      (clk_16m),
      .rst      (rst),
      .en       (adv),
      .clear    (!adv),
      .div      (div_active),
      .ovs_tick (ovs_tick)
   );
`else
   assign ovs_tick = 1'b0;
`endif

endmodule

// File: tb/tb_baud_gen.sv
// Bench for baud_gen: directed timing checks plus randomized rate/sync/enable
// traffic compared cycle by cycle against a period-level reference model.
module tb_baud_gen;

   localparam int CLK_HZ = 16_000_000;
   localparam int DIV_W  = 16;
   localparam int OVS    = 16;
`ifdef BAUD_OVS_EN
   localparam int NMIN   = OVS;
   localparam bit OVS_ON = 1'b1;
`else
   localparam int NMIN   = 2;
   localparam bit OVS_ON = 1'b0;
`endif

   logic             clk_16m = 1'b0;
   logic             rst;
   logic             en;
   logic [2:0]       bps_set;
   logic [DIV_W-1:0] div_custom;
   logic             sync;
   logic             clk_bps;
   logic             bps_tick;
   logic             ovs_tick;
   logic [DIV_W-1:0] div_active;

   baud_gen #(
      .CLK_HZ (CLK_HZ),
      .DIV_W  (DIV_W),
      .OVS    (OVS)
   ) dut (
      .clk_16m    (clk_16m),
      .rst        (rst),
      .en         (en),
      .bps_set    (bps_set),
      .div_custom (div_custom),
      .sync       (sync),
      .clk_bps    (clk_bps),
      .bps_tick   (bps_tick),
      .ovs_tick   (ovs_tick),
      .div_active (div_active)
   );

   // ---------------- clock ----------------
   always #5 clk_16m = ~clk_16m;

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int rate_tab [0:6] = '{9600, 19200, 38400, 57600, 115200, 4800, 2400};

   // reference model: period length, edges counted in the current period
   bit m_run;
   int m_n;
   int m_k;
   bit e_clk, e_bps, e_ovs;

   // measurements taken from observed outputs
   int last_tick_cyc, period, ovs_cnt, ovs_last, hi_cnt, hi_last;
   int last_ovs_cyc, gap_min, gap_max;

   task automatic report();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
         if (n_fail >= 40) begin
            report();
            $finish;
         end
      end
   endtask

   function automatic int sel_n(input int code, input int custom);
      int n;
      if (code == 7) n = custom;
      else n = (CLK_HZ + rate_tab[code] / 2) / rate_tab[code];
      if (n < NMIN) n = NMIN;
      return n;
   endfunction

   // Expected outputs after the next edge, from the inputs now applied.
   task automatic model_edge();
      if (rst) begin
         m_run = 0; m_k = 0; m_n = sel_n(0, 0);
         e_clk = 0; e_bps = 0; e_ovs = 0;
      end else if (!en) begin
         m_run = 0; m_k = 0;
         e_clk = 0; e_bps = 0; e_ovs = 0;
      end else if (!m_run || sync) begin
         e_clk = m_run && (m_k >= m_n / 2);
         e_bps = 0; e_ovs = 0;
         m_run = 1; m_k = 0; m_n = sel_n(bps_set, div_custom);
      end else begin
         e_clk = (m_k >= m_n / 2);
         m_k++;
         e_bps = (m_k == m_n);
         e_ovs = OVS_ON && (((m_k * OVS) / m_n) != (((m_k - 1) * OVS) / m_n));
         if (m_k == m_n) begin
            m_k = 0;
            m_n = sel_n(bps_set, div_custom);
         end
      end
   endtask

   task automatic clear_meas();
      ovs_cnt = 0; hi_cnt = 0; gap_min = 1 << 30; gap_max = 0;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk_16m);
      #1;
      cyc++;
      check("clk_bps", clk_bps, e_clk);
      check("bps_tick", bps_tick, e_bps);
      check("ovs_tick", ovs_tick, e_ovs);
      check("div_active", div_active, m_n);
      if (clk_bps) hi_cnt++;
      if (ovs_tick) begin
         ovs_cnt++;
         if (cyc - last_ovs_cyc < gap_min) gap_min = cyc - last_ovs_cyc;
         if (cyc - last_ovs_cyc > gap_max) gap_max = cyc - last_ovs_cyc;
         last_ovs_cyc = cyc;
      end
      if (bps_tick) begin
         period = cyc - last_tick_cyc;
         last_tick_cyc = cyc;
         ovs_last = ovs_cnt; ovs_cnt = 0;
         hi_last = hi_cnt; hi_cnt = 0;
      end
   endtask

   task automatic run_to_tick(input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (bps_tick) break;
      end
      check("tick_timeout", bps_tick, 1);
   endtask

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      report();
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      int s;
      int code;
      int len;
      rst = 1; en = 0; sync = 0; bps_set = 0; div_custom = '0;
      m_run = 0; m_k = 0; m_n = sel_n(0, 0);
      last_tick_cyc = 0; last_ovs_cyc = 0; period = 0; ovs_last = 0; hi_last = 0;
      clear_meas();
      repeat (2) @(posedge clk_16m);
      #1;
      check("rst_clk", clk_bps, 0);
      check("rst_tick", bps_tick, 0);
      check("rst_ovs", ovs_tick, 0);
      check("rst_div", div_active, 1667);
      rst = 0;
      repeat (3) step();

      // base rate, first tick latency from the first counting cycle
      en = 1;
      step();
      s = cyc;
      run_to_tick(1700);
      check("first_lat", cyc - s, 1667);
      clear_meas();
      run_to_tick(1700);
      check("base_period", period, 1667);
      check("clk_hi", hi_last, 834);
      check("clk_lo", period - hi_last, 833);
      if (OVS_ON) begin
         check("ovs_per_bit", ovs_last, 16);
         check("ovs_gap_min", gap_min, 104);
         check("ovs_gap_max", gap_max, 105);
         check("ovs_coinc", ovs_tick, 1);
      end

      // mid-period rate change completes the running period
      repeat (500) step();
      bps_set = 4;
      step();
      check("div_hold", div_active, 1667);
      run_to_tick(1700);
      check("chg_period", period, 1667);
      check("chg_div", div_active, 139);
      run_to_tick(200);
      check("fast_period1", period, 139);
      run_to_tick(200);
      check("fast_period2", period, 139);

      // phase restart mid-period
      bps_set = 0;
      run_to_tick(200);
      repeat (900) step();
      sync = 1;
      step();
      sync = 0;
      s = cyc;
      check("sync_no_tick", bps_tick, 0);
      ovs_cnt = 0;
      run_to_tick(1700);
      check("sync_lat", cyc - s, 1667);
      if (OVS_ON) check("sync_ovs", ovs_last, 16);

      // custom divisor clamp
      bps_set = 7; div_custom = 5;
      run_to_tick(1700);
      check("clamp5_div", div_active, OVS_ON ? 16 : 5);
      run_to_tick(40);
      check("clamp5_period", period, OVS_ON ? 16 : 5);
      div_custom = 1;
      run_to_tick(40);
      check("clamp1_div", div_active, OVS_ON ? 16 : 2);
      run_to_tick(40);
      check("clamp1_period", period, OVS_ON ? 16 : 2);

      // asynchronous reset mid-period
      bps_set = 0;
      run_to_tick(40);
      repeat (1000) step();
      rst = 1;
      #1;
      check("arst_clk", clk_bps, 0);
      check("arst_tick", bps_tick, 0);
      check("arst_ovs", ovs_tick, 0);
      check("arst_div", div_active, 1667);
      repeat (3) step();
      rst = 0;
      step();
      s = cyc;
      run_to_tick(1700);
      check("rst_restart", cyc - s, 1667);

      // enable gap with a new rate picked up on restart
      repeat (300) step();
      en = 0; bps_set = 3;
      for (int i = 0; i < 50; i++) begin
         step();
         check("gap_out", {29'd0, clk_bps, bps_tick, ovs_tick}, 0);
      end
      en = 1;
      step();
      s = cyc;
      run_to_tick(400);
      check("en_restart", cyc - s, 278);
      check("en_div", div_active, 278);

      // sync landing on a period boundary suppresses that tick
      bps_set = 4;
      run_to_tick(400);
      repeat (138) step();
      sync = 1;
      step();
      sync = 0;
      s = cyc;
      check("sync_bnd_tick", bps_tick, 0);
      run_to_tick(200);
      check("sync_bnd_lat", cyc - s, 139);

      // randomized traffic against the model
      for (int seg = 0; seg < 150; seg++) begin
         code = $urandom_range(0, 7);
         if ((code == 0 || code == 5 || code == 6) && $urandom_range(0, 3) != 0) code = 4;
         bps_set = 3'(code);
         div_custom = DIV_W'($urandom_range(0, 60));
         en = ($urandom_range(0, 7) != 0);
         len = $urandom_range(20, 400);
         for (int i = 0; i < len; i++) begin
            sync = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 49) == 0) div_custom = DIV_W'($urandom_range(0, 60));
            step();
         end
         sync = 0;
      end

      report();
      $finish;
   end

endmodule
